// File: rtl/spi_ram_target_if.sv
// SPI pin bundle plus status outputs for the SPI SRAM responder.
// master = initiator/bench side, slave = spi_ram_target side.
interface spi_ram_target_if;
    logic spi_select;
    logic spi_clk;
    logic spi_mosi;
    logic spi_miso;
    logic active;
    logic bad_cmd;

    modport master (
        output spi_select, spi_clk, spi_mosi,
        input  spi_miso, active, bad_cmd
    );

    modport slave (
        input  spi_select, spi_clk, spi_mosi,
        output spi_miso, active, bad_cmd
    );
endinterface

// File: rtl/spi_ram_target.sv
// SPI serial-RAM responder (cmd 0x03 read / 0x02 write, 16-bit address, auto-increment),
// oversampled in clk. Define SPI_RAM_TARGET_RDSR_EN to accept 0x05 read-status / 0x01 write-status.
module spi_ram_target #(
    parameter int ADDR_BITS = 16,
    parameter int MEM_BYTES = 256
) (
    input  logic             clk,
    input  logic             rst,
    spi_ram_target_if.slave  bus
);
    // state    | meaning
    // IDLE     | deselected, waiting for select low
    // CMD      | shifting the 8-bit command
    // ADDR     | shifting the address
    // READ     | streaming mem bytes on MISO
    // WRITE    | collecting bytes into mem
    // IGNORE   | bad command or reset mid-transaction; wait for deselect
    // STATUS   | streaming status byte 0x40 (RDSR build only)
    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_READ, ST_WRITE, ST_IGNORE, ST_STATUS
    } state_t;

    localparam int           IDX_BITS  = $clog2(MEM_BYTES);
    localparam logic [4:0]   ADDR_LAST = 5'(ADDR_BITS - 1);
    localparam logic [7:0]   STATUS_SEQ = 8'h40;

    state_t      state_q;
    logic [1:0]  sync_sel_q, sync_clk_q, sync_mosi_q;
    logic        clk_prev_q;
    logic [1:0]  settle_q;
    logic        post_rst_q;
    logic [4:0]  bit_cnt_q;
    logic [14:0] shift_q;
    logic [15:0] addr_q;
    logic [7:0]  dout_q;
    logic        is_write_q;
    logic        miso_q;
    logic        bad_cmd_q;

    logic [7:0]  mem [MEM_BYTES];

    logic        sel_s, mosi_s, rise, fall, mem_we;
    logic [7:0]  cmd_byte, mem_rd, tx_byte;
    logic [15:0] addr_shifted;
    logic [IDX_BITS-1:0] addr_idx;

    assign sel_s        = sync_sel_q[1];
    assign mosi_s       = sync_mosi_q[1];
    assign rise         = sync_clk_q[1] & ~clk_prev_q;
    assign fall         = ~sync_clk_q[1] & clk_prev_q;
    assign cmd_byte     = {shift_q[6:0], mosi_s};
    assign addr_shifted = {shift_q, mosi_s};
    assign addr_idx     = addr_q[IDX_BITS-1:0];
    assign mem_rd       = mem[addr_idx];
    assign tx_byte      = (state_q == ST_READ) ? mem_rd : STATUS_SEQ;
    assign mem_we       = !rst && !sel_s && rise && (state_q == ST_WRITE) && (bit_cnt_q == 5'd7);

    assign bus.spi_miso = miso_q;
    assign bus.active   = (state_q != ST_IDLE);
    assign bus.bad_cmd  = bad_cmd_q;

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_idx] <= cmd_byte;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_sel_q  <= 2'b11;
            sync_clk_q  <= 2'b00;
            sync_mosi_q <= 2'b00;
            clk_prev_q  <= 1'b0;
            settle_q    <= 2'd0;
            post_rst_q  <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 5'd0;
            shift_q     <= '0;
            addr_q      <= '0;
            dout_q      <= '0;
            is_write_q  <= 1'b0;
            miso_q      <= 1'b0;
            bad_cmd_q   <= 1'b0;
        end else begin
            sync_sel_q  <= {sync_sel_q[0], bus.spi_select};
            sync_clk_q  <= {sync_clk_q[0], bus.spi_clk};
            sync_mosi_q <= {sync_mosi_q[0], bus.spi_mosi};
            clk_prev_q  <= sync_clk_q[1];
            bad_cmd_q   <= 1'b0;
            // A select already low when the synchronizer refills after reset is a
            // transaction we joined midway, so it must not be decoded as a command.
            if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
            else if (sel_s) post_rst_q <= 1'b0;

            if (sel_s) begin
                state_q   <= ST_IDLE;
                miso_q    <= 1'b0;
                bit_cnt_q <= 5'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        bit_cnt_q <= 5'd0;
                        shift_q   <= '0;
                        state_q   <= post_rst_q ? ST_IGNORE : ST_CMD;
                    end
                    ST_CMD: if (rise) begin
                        shift_q   <= {shift_q[13:0], mosi_s};
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_q <= 5'd0;
                            shift_q   <= '0;
                            case (cmd_byte)
                                8'h03: begin is_write_q <= 1'b0; state_q <= ST_ADDR; end
                                8'h02: begin is_write_q <= 1'b1; state_q <= ST_ADDR; end
`ifdef SPI_RAM_TARGET_RDSR_EN
                                8'h05: state_q <= ST_STATUS;
                                8'h01: state_q <= ST_IGNORE;
`endif
                                default: begin
                                    state_q   <= ST_IGNORE;
                                    bad_cmd_q <= 1'b1;
                                end
                            endcase
                        end
                    end
                    ST_ADDR: if (rise) begin
                        shift_q   <= {shift_q[13:0], mosi_s};
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == ADDR_LAST) begin
                            addr_q    <= addr_shifted;
                            bit_cnt_q <= 5'd0;
                            state_q   <= is_write_q ? ST_WRITE : ST_READ;
                        end
                    end
                    ST_READ, ST_STATUS: if (fall) begin
                        if (bit_cnt_q == 5'd0) begin
                            miso_q    <= tx_byte[7];
                            dout_q    <= {tx_byte[6:0], 1'b0};
                            bit_cnt_q <= 5'd1;
                            if (state_q == ST_READ) addr_q <= addr_q + 16'd1;
                        end else begin
                            miso_q    <= dout_q[7];
                            dout_q    <= {dout_q[6:0], 1'b0};
                            bit_cnt_q <= (bit_cnt_q == 5'd7) ? 5'd0 : bit_cnt_q + 5'd1;
                        end
                    end
                    ST_WRITE: if (rise) begin
                        shift_q   <= {shift_q[13:0], mosi_s};
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_q <= 5'd0;
                            addr_q    <= addr_q + 16'd1;
                        end
                    end
                    ST_IGNORE: miso_q <= 1'b0;
                    default:   state_q <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_ram_target.sv
// Directed bench for spi_ram_target: SPI mode-0 initiator at clk/8 with hand-computed expectations.
module tb_spi_ram_target;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   bad_cnt = 0;
    int   miso_hi_cnt = 0;
    int   bad0, hi0;
    logic [7:0] r, d0, d1, d2;

    spi_ram_target_if bus ();

    spi_ram_target #(.ADDR_BITS(16), .MEM_BYTES(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.bad_cmd === 1'b1) bad_cnt++;
        if (bus.spi_miso === 1'b1) miso_hi_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic rb);
        bus.spi_mosi = b;
        wait_clk(4);
        rb = bus.spi_miso;
        bus.spi_clk = 1'b1;
        wait_clk(4);
        bus.spi_clk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
    endtask

    task automatic sel_begin();
        bus.spi_select = 1'b0;
        wait_clk(4);
    endtask

    task automatic sel_end();
        wait_clk(4);
        bus.spi_select = 1'b1;
        wait_clk(8);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] b0, input logic [7:0] b1, input int n);
        logic [7:0] x;
        sel_begin();
        spi_byte(8'h02, x);
        spi_byte(a[15:8], x);
        spi_byte(a[7:0], x);
        spi_byte(b0, x);
        if (n > 1) spi_byte(b1, x);
        sel_end();
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] o0, output logic [7:0] o1);
        logic [7:0] x;
        sel_begin();
        spi_byte(8'h03, x);
        spi_byte(a[15:8], x);
        spi_byte(a[7:0], x);
        spi_byte(8'h00, o0);
        spi_byte(8'h00, o1);
        sel_end();
    endtask

    initial begin
        logic b;
        rst = 1'b1;
        bus.spi_select = 1'b1;
        bus.spi_clk = 1'b0;
        bus.spi_mosi = 1'b0;
        wait_clk(4);
        check("rst_miso", 16'(bus.spi_miso), 16'h0);
        check("rst_active", 16'(bus.active), 16'h0);
        check("rst_bad_cmd", 16'(bus.bad_cmd), 16'h0);
        rst = 1'b0;
        wait_clk(6);

        // write then read back
        sel_begin();
        spi_byte(8'h02, r);
        check("active_in_cmd", 16'(bus.active), 16'h1);
        spi_byte(8'h00, r);
        spi_byte(8'h10, r);
        spi_byte(8'hA5, r);
        spi_byte(8'h3C, r);
        wait_clk(4);
        bus.spi_select = 1'b1;
        wait_clk(3);
        check("active_drop_write", 16'(bus.active), 16'h0);
        wait_clk(5);
        rd(16'h0010, d0, d1);
        check("read_0010_b0", 16'(d0), 16'h00A5);
        check("read_0010_b1", 16'(d1), 16'h003C);

        // wrap-around and aliasing
        wr(16'h00FF, 8'h11, 8'h22, 2);
        rd(16'h0000, d0, d1);
        check("wrap_read_0000", 16'(d0), 16'h0022);
        rd(16'h00FF, d0, d1);
        check("wrap_read_00ff", 16'(d0), 16'h0011);
        check("wrap_read_00ff_next", 16'(d1), 16'h0022);
        rd(16'h0110, d0, d1);
        check("alias_0110", 16'(d0), 16'h00A5);

        // partial byte discarded
        wr(16'h0020, 8'h5E, 8'h00, 1);
        sel_begin();
        spi_byte(8'h02, r);
        spi_byte(8'h00, r);
        spi_byte(8'h20, r);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
        sel_end();
        rd(16'h0020, d0, d1);
        check("partial_keep", 16'(d0), 16'h005E);

        // unrecognised command
        bad0 = bad_cnt;
        sel_begin();
        spi_byte(8'h9A, r);
        wait_clk(1);
        hi0 = miso_hi_cnt;
        spi_byte(8'hFF, d0);
        spi_byte(8'hFF, d1);
        spi_byte(8'hFF, d2);
        check("bad_pulse_once", 16'(bad_cnt - bad0), 16'h1);
        check("bad_miso_b0", 16'(d0), 16'h0);
        check("bad_miso_b1", 16'(d1), 16'h0);
        check("bad_miso_b2", 16'(d2), 16'h0);
        check("bad_miso_never_high", 16'(miso_hi_cnt - hi0), 16'h0);
        wait_clk(4);
        bus.spi_select = 1'b1;
        wait_clk(3);
        check("bad_active_drop", 16'(bus.active), 16'h0);
        wait_clk(5);

        // reset during the 4th data bit of a read
        sel_begin();
        spi_byte(8'h03, r);
        spi_byte(8'h00, r);
        spi_byte(8'h10, r);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
        bus.spi_mosi = 1'b0;
        wait_clk(4);
        bus.spi_clk = 1'b1;
        wait_clk(2);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("rst_mid_miso", 16'(bus.spi_miso), 16'h0);
        wait_clk(1);
        bus.spi_clk = 1'b0;
        wait_clk(8);
        check("rst_mid_ignore_active", 16'(bus.active), 16'h1);
        bad0 = bad_cnt;
        hi0 = miso_hi_cnt;
        spi_byte(8'h03, d0);
        spi_byte(8'h00, d1);
        spi_byte(8'h10, d2);
        spi_byte(8'h00, r);
        check("rst_mid_rx0", 16'(d0), 16'h0);
        check("rst_mid_rx3", 16'(r), 16'h0);
        check("rst_mid_no_bad", 16'(bad_cnt - bad0), 16'h0);
        check("rst_mid_miso_low", 16'(miso_hi_cnt - hi0), 16'h0);
        sel_end();
        rd(16'h0010, d0, d1);
        check("post_rst_read_b0", 16'(d0), 16'h00A5);
        check("post_rst_read_b1", 16'(d1), 16'h003C);

        // read status / write status
        bad0 = bad_cnt;
        sel_begin();
        spi_byte(8'h05, r);
        spi_byte(8'h00, d0);
        spi_byte(8'h00, d1);
        sel_end();
`ifdef SPI_RAM_TARGET_RDSR_EN
        check("rdsr_b0", 16'(d0), 16'h0040);
        check("rdsr_b1", 16'(d1), 16'h0040);
        check("rdsr_no_bad", 16'(bad_cnt - bad0), 16'h0);
`else
        check("rdsr_off_b0", 16'(d0), 16'h0);
        check("rdsr_off_b1", 16'(d1), 16'h0);
        check("rdsr_off_bad", 16'(bad_cnt - bad0), 16'h1);
`endif
        bad0 = bad_cnt;
        sel_begin();
        spi_byte(8'h01, r);
        spi_byte(8'hFF, d0);
        sel_end();
        check("wrsr_rx", 16'(d0), 16'h0);
`ifdef SPI_RAM_TARGET_RDSR_EN
        check("wrsr_no_bad", 16'(bad_cnt - bad0), 16'h0);
`else
        check("wrsr_off_bad", 16'(bad_cnt - bad0), 16'h1);
`endif
        rd(16'h0010, d0, d1);
        check("final_read_b0", 16'(d0), 16'h00A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
